hazard_ctrl_seq: RTL

- Parametrised, sequential successor to the pipeline hazard unit of the 8-bit pipelined processor.
- Generates forwarding selects and per-stage enable/flush controls.
- The earlier unit was purely combinational. This block adds:
  - a state machine that holds multi-cycle load-use stalls and RET drains,
  - a data-memory wait freeze,
  - a saturating stall-event counter for debug.

---
 rtl/hazard_ctrl_seq.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl_seq.sv
// Sequential pipeline hazard controller: forwarding selects, stage enables/flushes,
// multi-cycle load-use and RET drain handling, memory-wait freeze, stall counter.
module hazard_ctrl_seq #(
    parameter int REG_AW       = 2,
    parameter int LOAD_BUBBLES = 1,
    parameter int RET_DRAIN    = 3,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs_D,
    input  logic [REG_AW-1:0] rt_D,
    input  logic              use_rs_D,
    input  logic              use_rt_D,
    input  logic [REG_AW-1:0] rs_E,
    input  logic [REG_AW-1:0] rt_E,
    input  logic              imm_b_E,
    input  logic [REG_AW-1:0] rd_E,
    input  logic              mem_read_E,
    input  logic [REG_AW-1:0] rd_M,
    input  logic              reg_write_M,
    input  logic [REG_AW-1:0] rd_W,
    input  logic              reg_write_W,
    input  logic              branch_taken_E,
    input  logic              is_ret_D,
    input  logic              mem_ready_M,
    output logic [1:0]        forward_a_E,
    output logic [1:0]        forward_b_E,
    output logic              en_F,
    output logic              en_D,
    output logic              en_E,
    output logic              en_M,
    output logic              flush_D,
    output logic              flush_E,
    output logic [CNT_W-1:0]  stall_events,
    output logic              busy
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        RET_WAIT   = 2'd1,
        LOAD_STALL = 2'd2
    } state_t;

    localparam logic [2:0]       RET_INIT  = 3'(RET_DRAIN - 1);
    localparam logic [2:0]       LOAD_INIT = 3'(LOAD_BUBBLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     state, state_n;
    logic [2:0] cnt, cnt_n;
    logic       count_evt;
    logic       load_use;
    logic       hit_a_m, hit_a_w, hit_b_m, hit_b_w;

    assign hit_a_m = reg_write_M && (rd_M == rs_E);
    assign hit_a_w = reg_write_W && (rd_W == rs_E);
    assign hit_b_m = reg_write_M && (rd_M == rt_E);
    assign hit_b_w = reg_write_W && (rd_W == rt_E);

    // M result is younger than W, so it wins when both match
    always_comb begin
        forward_a_E = 2'b00;
        forward_b_E = 2'b00;
        if (!rst) begin
            if (hit_a_m)      forward_a_E = 2'b10;
            else if (hit_a_w) forward_a_E = 2'b01;
            if (imm_b_E)      forward_b_E = 2'b00;
            else if (hit_b_m) forward_b_E = 2'b10;
            else if (hit_b_w) forward_b_E = 2'b01;
        end
    end

    assign load_use = mem_read_E &&
                      ((use_rs_D && (rd_E == rs_D)) ||
                       (use_rt_D && (rd_E == rt_D)));

    assign busy = (state != RUN);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        count_evt = 1'b0;
        en_F      = 1'b1;
        en_D      = 1'b1;
        en_E      = 1'b1;
        en_M      = 1'b1;
        flush_D   = 1'b0;
        flush_E   = 1'b0;

        case (state)
            RUN: begin
                if (branch_taken_E) begin
                    flush_D = 1'b1;
                    flush_E = 1'b1;
                end else if (is_ret_D) begin
                    en_F      = 1'b0;
                    flush_D   = 1'b1;
                    cnt_n     = RET_INIT;
                    count_evt = 1'b1;
                    state_n   = (RET_DRAIN == 1) ? RUN : RET_WAIT;
                end else if (load_use) begin
                    en_F      = 1'b0;
                    en_D      = 1'b0;
                    flush_E   = 1'b1;
                    cnt_n     = LOAD_INIT;
                    count_evt = 1'b1;
                    state_n   = (LOAD_BUBBLES == 2) ? LOAD_STALL : RUN;
                end
            end
            RET_WAIT: begin
                en_F    = 1'b0;
                flush_D = 1'b1;
                if (branch_taken_E) begin
                    // the RET itself resolving in Execute ends the drain early
                    flush_E = 1'b1;
                    cnt_n   = 3'd0;
                    state_n = RUN;
                end else if (cnt <= 3'd1) begin
                    cnt_n   = 3'd0;
                    state_n = RUN;
                end else begin
                    cnt_n = cnt - 3'd1;
                end
            end
            LOAD_STALL: begin
                cnt_n   = 3'd0;
                state_n = RUN;
                if (branch_taken_E) begin
                    flush_D = 1'b1;
                    flush_E = 1'b1;
                end else begin
                    en_F    = 1'b0;
                    en_D    = 1'b0;
                    flush_E = 1'b1;
                end
            end
            default: begin
                cnt_n   = 3'd0;
                state_n = RUN;
            end
        endcase

        // a data-memory wait state freezes the whole pipeline, FSM included
        if (!mem_ready_M) begin
            state_n   = state;
            cnt_n     = cnt;
            count_evt = 1'b0;
            en_F      = 1'b0;
            en_D      = 1'b0;
            en_E      = 1'b0;
            en_M      = 1'b0;
            flush_D   = 1'b0;
            flush_E   = 1'b0;
        end

        if (rst) begin
            en_F    = 1'b1;
            en_D    = 1'b1;
            en_E    = 1'b1;
            en_M    = 1'b1;
            flush_D = 1'b0;
            flush_E = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            cnt          <= 3'd0;
            stall_events <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (count_evt && !(&stall_events))
                stall_events <= stall_events + CNT_ONE;
        end
    end

endmodule
